// File: rtl/reg_share_arbiter_if.sv
// reg_share_arbiter_if
//   Bundles the request/write/grant signals of a three-requester shared
//   register arbiter.
//   req[2:0]    request, bit i from requester i
//   wr[2:0]     write strobe, bit i from requester i
//   wdata       3*WIDTH write data, slice [i*WIDTH +: WIDTH] from requester i
//   gnt[2:0]    one-hot grant (registered)
//   ack[2:0]    one-cycle write acknowledge (registered)
//   rdata       shared register value (registered)
//   busy        arbiter currently has an owner
//   master: requester side, slave: arbiter side.
interface reg_share_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [2:0]         req;
  logic [2:0]         wr;
  logic [3*WIDTH-1:0] wdata;
  logic [2:0]         gnt;
  logic [2:0]         ack;
  logic [WIDTH-1:0]   rdata;
  logic               busy;

  modport master (
    output req, wr, wdata,
    input  gnt, ack, rdata, busy
  );

  modport slave (
    input  req, wr, wdata,
    output gnt, ack, rdata, busy
  );
endinterface

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter
//   Round-robin arbiter granting one of three requesters ownership of a
//   shared WIDTH-bit register for at most MAX_HOLD consecutive cycles.
//   The owner may write the register; each accepted write is acknowledged
//   for one cycle. Every ownership is followed by at least one idle cycle.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  reg_share_arbiter_if slave modport (req/wr/wdata in,
//          gnt/ack/rdata/busy out)
module reg_share_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4   // legal range 1..15
) (
  input  logic               clk,
  input  logic               rst,
  reg_share_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       owner, owner_nxt;
  logic [1:0]       last, last_nxt;
  logic [3:0]       hold_cnt, hold_nxt;
  logic [2:0]       gnt_q, gnt_nxt;
  logic [2:0]       ack_q, ack_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;

  logic [1:0]       idx;
  logic [1:0]       winner;
  logic             winner_vld;
  logic             owner_req;
  logic             owner_wr;
  logic [WIDTH-1:0] owner_data;
  logic             release_now;

  // Round-robin search starting at last+1, wrapping 2 -> 0.
  always_comb begin
    idx        = last;
    winner     = '0;
    winner_vld = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!winner_vld && bus.req[idx]) begin
        winner     = idx;
        winner_vld = 1'b1;
      end
    end
  end

  // Signals of the current owner only; other requesters' strobes are ignored.
  always_comb begin
    owner_req  = 1'b0;
    owner_wr   = 1'b0;
    owner_data = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (owner == 2'(i)) begin
        owner_req  = bus.req[i];
        owner_wr   = bus.wr[i];
        owner_data = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign release_now = (state == GRANT) &&
                       (!owner_req || (hold_cnt == 4'(MAX_HOLD - 1)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (winner_vld)  state_nxt = GRANT;
      GRANT:   if (release_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values (registered below)
  always_comb begin
    gnt_nxt   = gnt_q;
    ack_nxt   = '0;
    shreg_nxt = shreg;
    hold_nxt  = hold_cnt;
    last_nxt  = last;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (winner_vld) begin
          gnt_nxt   = 3'b001 << winner;
          owner_nxt = winner;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        hold_nxt = hold_cnt + 4'd1;
        // A write is accepted even on the cycle the hold limit releases.
        if (owner_req && owner_wr) begin
          shreg_nxt = owner_data;
          ack_nxt   = 3'b001 << owner;
        end
        if (release_now) begin
          gnt_nxt  = '0;
          last_nxt = owner;
        end
      end
      default: gnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q    <= '0;
      ack_q    <= '0;
      shreg    <= '0;
      hold_cnt <= '0;
      last     <= 2'd2;
      owner    <= '0;
    end else begin
      gnt_q    <= gnt_nxt;
      ack_q    <= ack_nxt;
      shreg    <= shreg_nxt;
      hold_cnt <= hold_nxt;
      last     <= last_nxt;
      owner    <= owner_nxt;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = shreg;
  assign bus.busy  = (state == GRANT);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter
//   Directed bench for reg_share_arbiter: one instance with MAX_HOLD = 4 and
//   one with MAX_HOLD = 1, expected values computed by hand.
module tb_reg_share_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  reg_share_arbiter_if #(.WIDTH(8)) bus0 ();
  reg_share_arbiter_if #(.WIDTH(8)) bus1 ();

  reg_share_arbiter #(.WIDTH(8), .MAX_HOLD(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  reg_share_arbiter #(.WIDTH(8), .MAX_HOLD(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] eg;
    bus0.req = '0; bus0.wr = '0; bus0.wdata = '0;
    bus1.req = '0; bus1.wr = '0; bus1.wdata = '0;

    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_gnt",   32'(bus0.gnt),   32'h0);
    check("rst_ack",   32'(bus0.ack),   32'h0);
    check("rst_busy",  32'(bus0.busy),  32'h0);
    check("rst_rdata", 32'(bus0.rdata), 32'h0);

    // All requesting: 4 grant cycles, one idle cycle, rotating 0 -> 1 -> 2 -> 0
    bus0.req = 3'b111;
    for (int c = 0; c < 16; c++) begin
      step();
      eg = ((c % 5) < 4) ? (3'b001 << ((c / 5) % 3)) : 3'b000;
      check($sformatf("rr_gnt_c%0d", c), 32'(bus0.gnt), 32'(eg));
      check($sformatf("rr_busy_c%0d", c), 32'(bus0.busy), 32'((c % 5) < 4));
    end
    bus0.req = 3'b000;
    step();
    check("drop_gnt", 32'(bus0.gnt), 32'h0);
    step();
    check("idle_gnt", 32'(bus0.gnt), 32'h0);

    // Requester 1 alone, writes A5 then 5A back to back
    bus0.req = 3'b010; bus0.wr = 3'b010; bus0.wdata = {8'h00, 8'hA5, 8'h00};
    step();
    check("w1_gnt",    32'(bus0.gnt),   32'h2);
    check("w1_rdata0", 32'(bus0.rdata), 32'h00);
    check("w1_ack0",   32'(bus0.ack),   32'h0);
    step();
    check("w1_rdata",  32'(bus0.rdata), 32'hA5);
    check("w1_ack",    32'(bus0.ack),   32'h2);
    bus0.wdata = {8'h00, 8'h5A, 8'h00};
    step();
    check("w2_rdata",  32'(bus0.rdata), 32'h5A);
    check("w2_ack",    32'(bus0.ack),   32'h2);
    bus0.wr = 3'b000;
    step();
    check("w2_ack_end", 32'(bus0.ack),  32'h0);
    check("w2_hold",    32'(bus0.rdata), 32'h5A);
    bus0.req = 3'b000;
    step();
    check("w_rel_gnt", 32'(bus0.gnt), 32'h0);

    // Requester 0 owns; requester 2 write strobe must be ignored
    bus0.req = 3'b001; bus0.wr = 3'b100; bus0.wdata = {8'h3C, 8'h00, 8'h00};
    step();
    check("ng_gnt", 32'(bus0.gnt), 32'h1);
    step();
    check("ng_rdata", 32'(bus0.rdata), 32'h5A);
    check("ng_ack",   32'(bus0.ack),   32'h0);

    // req[0] drops after 2 grant cycles, pending req[2] follows after one idle
    bus0.req = 3'b100; bus0.wr = 3'b000;
    step();
    check("dr_gnt",  32'(bus0.gnt),  32'h0);
    check("dr_busy", 32'(bus0.busy), 32'h0);
    step();
    check("dr_next_gnt", 32'(bus0.gnt), 32'h4);

    // Hold-limit release with a simultaneous write, then round-robin re-compete
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("hl_gnt_c%0d", c), 32'(bus0.gnt), 32'h4);
    end
    bus0.req = 3'b101; bus0.wr = 3'b100; bus0.wdata = {8'hC3, 8'h00, 8'h00};
    step();
    check("hl_rel_gnt", 32'(bus0.gnt),   32'h0);
    check("hl_rdata",   32'(bus0.rdata), 32'hC3);
    check("hl_ack",     32'(bus0.ack),   32'h4);
    check("hl_busy",    32'(bus0.busy),  32'h0);
    bus0.wr = 3'b000;
    step();
    check("hl_next_gnt", 32'(bus0.gnt), 32'h1);
    check("hl_ack_end",  32'(bus0.ack), 32'h0);

    // Reset mid-grant; write sampled with reset is discarded
    bus0.req = 3'b001; bus0.wr = 3'b001; bus0.wdata = {8'h00, 8'h00, 8'h77};
    step();
    check("rm_rdata", 32'(bus0.rdata), 32'h77);
    check("rm_ack",   32'(bus0.ack),   32'h1);
    rst = 1'b1; bus0.wdata = {8'h00, 8'h00, 8'h99};
    step();
    check("rm_gnt",    32'(bus0.gnt),   32'h0);
    check("rm_rdata0", 32'(bus0.rdata), 32'h0);
    check("rm_busy",   32'(bus0.busy),  32'h0);
    check("rm_ack0",   32'(bus0.ack),   32'h0);
    rst = 1'b0; bus0.req = 3'b110; bus0.wr = 3'b000;
    step();
    check("rm_first_gnt", 32'(bus0.gnt), 32'h2);

    // MAX_HOLD = 1: one-cycle grants alternating with idle cycles
    bus0.req = 3'b000;
    bus1.req = 3'b011;
    for (int c = 0; c < 5; c++) begin
      step();
      eg = (c % 2 == 1) ? 3'b000 : ((c % 4 == 0) ? 3'b001 : 3'b010);
      check($sformatf("mh1_gnt_c%0d", c), 32'(bus1.gnt), 32'(eg));
      check($sformatf("mh1_busy_c%0d", c), 32'(bus1.busy), 32'(c % 2 == 0));
    end
    bus1.req = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, width of the shared storage register and each write-data slice.
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles per ownership; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  3  per-requester request; bit i belongs to requester i.
REQ-006 wr  input  3  per-requester write strobe; effective only while that requester is granted.
REQ-007 wdata  input  3*WIDTH  write data; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-008 gnt  output  3  registered one-hot grant; all-zero when no owner.
REQ-009 ack  output  3  registered one-cycle write acknowledge per requester.
REQ-010 rdata  output  WIDTH  current value of the shared register, registered.
REQ-011 busy  output  1  high while in GRANT state.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-013 IDLE: if req is nonzero, the block SHALL select a winner, assert gnt[winner] on the next edge, clear hold_cnt and enter GRANT; if req is zero, it SHALL remain in IDLE with gnt = 0.
REQ-014 Winner selection SHALL be round-robin: search starting at (last+1) mod 3, ascending with wrap, and choose the first index with req set.
REQ-015 GRANT, owner i: each cycle with req[i] = 1 and wr[i] = 1, the shared register SHALL load wdata slice i at the edge, and rdata SHALL show the new value from that edge.
REQ-016 An accepted write SHALL pulse ack[i] high for exactly the cycle after acceptance; back-to-back writes SHALL produce back-to-back ack pulses.
REQ-017 wr from any non-granted requester SHALL be ignored: no register change and no ack.
REQ-018 hold_cnt SHALL increment once per GRANT cycle.
REQ-019 Release SHALL occur at the edge where req[i] = 0 is sampled, or where hold_cnt = MAX_HOLD-1 is sampled, whichever comes first.
REQ-020 On release, gnt SHALL go to 0, last SHALL be set to i, and the FSM SHALL return to IDLE.
REQ-021 A write sampled in the same cycle as a hold-limit release SHALL still be accepted and acknowledged.
REQ-022 Every ownership SHALL be followed by at least one IDLE cycle with gnt = 0.
REQ-023 A forced release SHALL not be extended by a continuing req[i]; the requester re-competes in round-robin order.
REQ-024 gnt SHALL never have more than one bit set.
REQ-025 busy SHALL equal (state == GRANT).
REQ-026 With MAX_HOLD = 1, each grant SHALL last exactly one cycle.

Reset
REQ-027 When rst = 1 at an edge, the block SHALL take these values: state = IDLE, gnt = 0, ack = 0, busy = 0, shared register = 0, rdata = 0, hold_cnt = 0, last = 2, so requester 0 has first priority.
REQ-028 Reset SHALL override any in-progress grant or write; a write sampled together with rst SHALL be discarded and SHALL not be acknowledged.

Verification
REQ-029 Reset, then req = 3'b111 held -> gnt sequence 001, 000, 010, 000, 100, 000, 001; each grant lasts MAX_HOLD = 4 cycles.
REQ-030 Only req[1] = 1 with wr[1] = 1 and slice1 = 8'hA5 -> gnt = 010 next cycle; rdata = 8'hA5 after the first write edge; ack = 010 the following cycle.
REQ-031 Requester 0 granted while wr[2] = 1 and slice2 = 8'h3C -> rdata unchanged and ack[2] stays 0.
REQ-032 req[0] drops after 2 grant cycles -> gnt = 000 on the next edge; last = 0; a pending req[2] is granted after one IDLE cycle.
REQ-033 rst asserted mid-grant after writing 8'h77 -> next edge gnt = 0, rdata = 0, busy = 0; with req = 3'b110 afterwards, requester 1 wins first.
REQ-034 MAX_HOLD = 1 with req = 3'b011 -> grants alternate 01, 00, 10, 00, each one cycle long.
